ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit with its own fetch PC, a configurable number of outstanding bus reads, and an instruction prefetch FIFO. It sits between the PC/branch logic and decode, and masters the vrb bus. Jump redirect flushes the FIFO and discards stale in-flight responses. A bus error halts fetching until the next redirect.

---
 rtl/ifu_prefetch.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ifu_prefetch.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// ----------------------------------------------------------------------------
// ifu_prefetch
//
// Instruction fetch unit. It owns the fetch PC, issues in-order read requests
// on the vrb bus with up to MAX_OS reads in flight, and buffers returned
// instructions in a DEPTH-entry prefetch FIFO feeding decode.
//
// A jump redirect flushes the FIFO and restarts fetching at the (aligned)
// target. Responses for reads issued before the jump are still counted as
// outstanding and are dropped when they arrive. A bus error on a kept
// response halts fetching until the next jump.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_jump_valid/i_jump_pc    redirect request and target
//   o_ifu_vrb_cmd_*           read request channel (read-only master)
//   i_ifu_vrb_cmd_ready       request accepted by the bus
//   i_ifu_vrb_rsp_*           in-order read response channel
//   o_instr_valid/o_pc/o_instr/o_err   FIFO head towards decode
//   i_instr_ready             decode consumes the head
//   o_holding                 decode must stall (no valid head)
//
// Handshake semantics (both channels towards/from this block):
//   A transfer happens only in a cycle where valid && ready are both high.
//   o_ifu_vrb_cmd_valid is allowed to drop without a transfer only in a jump
//   cycle, on entry to HALT, or under reset. The response channel has no
//   ready: every i_ifu_vrb_rsp_valid cycle is consumed. The decode side pops
//   the head on o_instr_valid && i_instr_ready.
// ----------------------------------------------------------------------------
module ifu_prefetch #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            DEPTH    = 4,
    parameter int            MAX_OS   = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            i_jump_valid,
    input  logic [AW-1:0]   i_jump_pc,

    output logic            o_ifu_vrb_cmd_valid,
    input  logic            i_ifu_vrb_cmd_ready,
    output logic [AW-1:0]   o_ifu_vrb_cmd_addr,
    output logic            o_ifu_vrb_cmd_read,
    output logic [DW-1:0]   o_ifu_vrb_cmd_wdata,
    output logic [DW/8-1:0] o_ifu_vrb_cmd_wmask,

    input  logic            i_ifu_vrb_rsp_valid,
    input  logic            i_ifu_vrb_rsp_err,
    input  logic [DW-1:0]   i_ifu_vrb_rsp_rdata,

    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [AW-1:0]   o_pc,
    output logic [DW-1:0]   o_instr,
    output logic            o_err,
    output logic            o_holding
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int BW  = DW / 8;                          // bytes per fetch
    localparam int FPW = $clog2(DEPTH);                   // FIFO pointer
    localparam int FCW = $clog2(DEPTH + 1);               // FIFO count
    localparam int TPW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1; // tag pointer
    localparam int OCW = $clog2(MAX_OS + 1);              // outstanding count
    localparam int SW  = $clog2(DEPTH + MAX_OS + 1);      // credit sum

    localparam logic [AW-1:0] PC_STEP    = AW'(BW);
    // Clears the byte-offset bits of a jump target.
    localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(BW - 1));

    // FSM encoding
    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HALT  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]     state;
    logic [AW-1:0]  fetch_pc;

    // PC tags of in-flight reads, in issue order. Entry count == os_cnt.
    logic [AW-1:0]  tag_mem [MAX_OS];
    logic [TPW-1:0] tag_wr_ptr;
    logic [TPW-1:0] tag_rd_ptr;

    // os_cnt includes reads whose responses will be discarded; disc_cnt is
    // how many of the oldest in-flight reads belong to a flushed stream.
    logic [OCW-1:0] os_cnt;
    logic [OCW-1:0] disc_cnt;

    // Prefetch FIFO of {err, instr, pc}.
    logic [AW-1:0]  fifo_pc    [DEPTH];
    logic [DW-1:0]  fifo_instr [DEPTH];
    logic           fifo_err   [DEPTH];
    logic [FPW-1:0] fifo_wr_ptr;
    logic [FPW-1:0] fifo_rd_ptr;
    logic [FCW-1:0] fifo_cnt;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic           cmd_fire;
    logic           os_ok;
    logic           credit_ok;
    logic           rsp_drop;
    logic           fifo_push;
    logic           fifo_pop;
    logic [AW-1:0]  rsp_tag;
    logic [OCW-1:0] os_cnt_nxt;
    logic [OCW-1:0] disc_cnt_nxt;
    logic [FCW-1:0] fifo_cnt_nxt;

    function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
        if (p == TPW'(MAX_OS - 1)) begin
            return '0;
        end
        return p + TPW'(1);
    endfunction

    assign os_ok = (os_cnt < OCW'(MAX_OS));

    // Every in-flight read (kept or discarded) reserves a FIFO slot, so the
    // FIFO can never be pushed while full.
    assign credit_ok = ((SW'(fifo_cnt) + SW'(os_cnt)) < SW'(DEPTH));

    assign o_ifu_vrb_cmd_valid = !rst && (state == ST_FETCH) && !i_jump_valid
                                 && os_ok && credit_ok;
    assign o_ifu_vrb_cmd_addr  = fetch_pc;
    assign o_ifu_vrb_cmd_read  = 1'b1;
    assign o_ifu_vrb_cmd_wdata = '0;
    assign o_ifu_vrb_cmd_wmask = '0;

    assign cmd_fire = o_ifu_vrb_cmd_valid && i_ifu_vrb_cmd_ready;

    assign rsp_tag  = tag_mem[tag_rd_ptr];

    // A response belongs to a flushed stream if discards are pending, and a
    // response arriving in the jump cycle itself is also stale.
    assign rsp_drop  = i_jump_valid || (disc_cnt != '0);
    assign fifo_push = i_ifu_vrb_rsp_valid && !rsp_drop;

    // The head is hidden in a jump cycle so decode never sees a stale PC.
    assign o_instr_valid = !rst && !i_jump_valid && (fifo_cnt != '0);
    assign o_holding     = !o_instr_valid;
    assign fifo_pop      = o_instr_valid && i_instr_ready;

    assign o_pc    = fifo_pc[fifo_rd_ptr];
    assign o_instr = fifo_instr[fifo_rd_ptr];
    assign o_err   = fifo_err[fifo_rd_ptr];

    always_comb begin
        os_cnt_nxt = os_cnt;
        if (cmd_fire && !i_ifu_vrb_rsp_valid) begin
            os_cnt_nxt = os_cnt + OCW'(1);
        end else if (!cmd_fire && i_ifu_vrb_rsp_valid) begin
            os_cnt_nxt = os_cnt - OCW'(1);
        end
    end

    always_comb begin
        disc_cnt_nxt = disc_cnt;
        if (i_jump_valid) begin
            // No command can be accepted in a jump cycle, so everything still
            // in flight after this cycle is stale.
            disc_cnt_nxt = i_ifu_vrb_rsp_valid ? (os_cnt - OCW'(1)) : os_cnt;
        end else if (i_ifu_vrb_rsp_valid && (disc_cnt != '0)) begin
            disc_cnt_nxt = disc_cnt - OCW'(1);
        end
    end

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (i_jump_valid) begin
            fifo_cnt_nxt = '0;
        end else if (fifo_push && !fifo_pop) begin
            fifo_cnt_nxt = fifo_cnt + FCW'(1);
        end else if (!fifo_push && fifo_pop) begin
            fifo_cnt_nxt = fifo_cnt - FCW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            os_cnt      <= '0;
            disc_cnt    <= '0;
            tag_wr_ptr  <= '0;
            tag_rd_ptr  <= '0;
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_cnt    <= '0;
        end else begin
            os_cnt   <= os_cnt_nxt;
            disc_cnt <= disc_cnt_nxt;
            fifo_cnt <= fifo_cnt_nxt;

            if (cmd_fire) begin
                tag_wr_ptr <= tag_inc(tag_wr_ptr);
            end
            if (i_ifu_vrb_rsp_valid) begin
                tag_rd_ptr <= tag_inc(tag_rd_ptr);
            end

            if (fifo_push) begin
                fifo_wr_ptr <= fifo_wr_ptr + FPW'(1);
            end
            // Nothing is pushed in a jump cycle, so wr_ptr is stable and
            // moving rd_ptr onto it empties the FIFO.
            if (i_jump_valid) begin
                fifo_rd_ptr <= fifo_wr_ptr;
            end else if (fifo_pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + FPW'(1);
            end

            if (i_jump_valid) begin
                fetch_pc <= i_jump_pc & ALIGN_MASK;
                state    <= ST_FETCH;
            end else begin
                if (cmd_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                // Only an error on a kept response halts; a stale error
                // belongs to an abandoned stream.
                if (fifo_push && i_ifu_vrb_rsp_err) begin
                    state <= ST_HALT;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage (no reset needed: contents are qualified by the counters)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            tag_mem[tag_wr_ptr] <= fetch_pc;
        end
        if (fifo_push) begin
            fifo_pc[fifo_wr_ptr]    <= rsp_tag;
            fifo_instr[fifo_wr_ptr] <= i_ifu_vrb_rsp_rdata;
            fifo_err[fifo_wr_ptr]   <= i_ifu_vrb_rsp_err;
        end
    end

    // A response with nothing in flight means the bus broke ordering.
    rsp_without_request: assert property (
        @(posedge clk) disable iff (rst)
        !(i_ifu_vrb_rsp_valid && (os_cnt == '0))
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_prefetch
//
// Bench for ifu_prefetch. Inputs are driven on the falling edge and outputs
// are sampled 1 time unit later. The reference model tracks the fetch
// stream as queues: in-flight reads (pc plus a stale flag) and the expected
// FIFO contents {err, instr, pc}. A small bus model answers reads in order
// with data derived from the address.
// ----------------------------------------------------------------------------
module tb_ifu_prefetch;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int MAX_OS = 2;
  localparam int EW     = 1 + DW + AW;

  // ------------------------------------------------------------------
  // Clock / reset / DUT
  // ------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_jump_valid = 1'b0;
  logic [AW-1:0] i_jump_pc = '0;
  logic          o_ifu_vrb_cmd_valid;
  logic          i_ifu_vrb_cmd_ready = 1'b0;
  logic [AW-1:0] o_ifu_vrb_cmd_addr;
  logic          o_ifu_vrb_cmd_read;
  logic [DW-1:0] o_ifu_vrb_cmd_wdata;
  logic [DW/8-1:0] o_ifu_vrb_cmd_wmask;
  logic          i_ifu_vrb_rsp_valid = 1'b0;
  logic          i_ifu_vrb_rsp_err = 1'b0;
  logic [DW-1:0] i_ifu_vrb_rsp_rdata = '0;
  logic          o_instr_valid;
  logic          i_instr_ready = 1'b0;
  logic [AW-1:0] o_pc;
  logic [DW-1:0] o_instr;
  logic          o_err;
  logic          o_holding;

  ifu_prefetch #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_OS(MAX_OS), .RESET_PC('0)
  ) u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_jump_valid        (i_jump_valid),
    .i_jump_pc           (i_jump_pc),
    .o_ifu_vrb_cmd_valid (o_ifu_vrb_cmd_valid),
    .i_ifu_vrb_cmd_ready (i_ifu_vrb_cmd_ready),
    .o_ifu_vrb_cmd_addr  (o_ifu_vrb_cmd_addr),
    .o_ifu_vrb_cmd_read  (o_ifu_vrb_cmd_read),
    .o_ifu_vrb_cmd_wdata (o_ifu_vrb_cmd_wdata),
    .o_ifu_vrb_cmd_wmask (o_ifu_vrb_cmd_wmask),
    .i_ifu_vrb_rsp_valid (i_ifu_vrb_rsp_valid),
    .i_ifu_vrb_rsp_err   (i_ifu_vrb_rsp_err),
    .i_ifu_vrb_rsp_rdata (i_ifu_vrb_rsp_rdata),
    .o_instr_valid       (o_instr_valid),
    .i_instr_ready       (i_instr_ready),
    .o_pc                (o_pc),
    .o_instr             (o_instr),
    .o_err               (o_err),
    .o_holding           (o_holding)
  );

  // ------------------------------------------------------------------
  // Scoreboard / model state
  // ------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];     // expected FIFO contents {err, instr, pc}
  logic [AW:0]   os_q[$];      // in-flight reads {stale, pc}
  logic [AW-1:0] m_pc;
  bit            m_halt;

  logic [AW-1:0] bus_q[$];     // bus side: addresses awaiting a response

  logic [AW-1:0] acc_log[$];   // DUT accepted addresses
  logic [AW-1:0] pc_log[$];    // DUT popped PCs
  logic          err_log[$];   // DUT popped error flags

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_cmd_valid();
    return !m_halt && !i_jump_valid && (os_q.size() < MAX_OS)
           && ((exp_q.size() + os_q.size()) < DEPTH);
  endfunction

  function automatic bit m_instr_valid();
    return (exp_q.size() > 0) && !i_jump_valid;
  endfunction

  // Per-cycle comparison of all DUT outputs against the model.
  task automatic compare();
    bit ecv;
    bit eiv;
    logic [EW-1:0] h;
    ecv = m_cmd_valid();
    eiv = m_instr_valid();
    chk("cmd_valid", o_ifu_vrb_cmd_valid, ecv);
    if (ecv) chk("cmd_addr", o_ifu_vrb_cmd_addr, m_pc);
    chk("cmd_const", {o_ifu_vrb_cmd_read, o_ifu_vrb_cmd_wmask, o_ifu_vrb_cmd_wdata}, {1'b1, 4'h0, 32'h0});
    chk("instr_valid", o_instr_valid, eiv);
    chk("holding", o_holding, !eiv);
    if (eiv) begin
      h = exp_q[0];
      chk("head_pc", o_pc, h[AW-1:0]);
      chk("head_instr", o_instr, h[AW+DW-1:AW]);
      chk("head_err", o_err, h[EW-1]);
    end
  endtask

  // ------------------------------------------------------------------
  // Driver tasks
  // ------------------------------------------------------------------
  task automatic drive(input bit j, input logic [AW-1:0] jpc, input bit cr,
                       input bit want_rv, input bit rerr, input bit ir);
    i_jump_valid        = j;
    i_jump_pc           = jpc;
    i_ifu_vrb_cmd_ready = cr;
    if (want_rv && bus_q.size() > 0) begin
      i_ifu_vrb_rsp_valid = 1'b1;
      i_ifu_vrb_rsp_rdata = mem_word(bus_q[0]);
      i_ifu_vrb_rsp_err   = rerr;
    end else begin
      i_ifu_vrb_rsp_valid = 1'b0;
      i_ifu_vrb_rsp_rdata = '0;
      i_ifu_vrb_rsp_err   = 1'b0;
    end
    i_instr_ready = ir;
    #1;
    compare();
  endtask

  // Advance model and bus by one cycle, then wait for the next falling edge.
  task automatic advance();
    bit ecv;
    bit eiv;
    logic [AW:0] t;
    ecv = m_cmd_valid();
    eiv = m_instr_valid();
    t = '0;
    if (i_ifu_vrb_rsp_valid && os_q.size() > 0) t = os_q.pop_front();
    if (i_jump_valid) begin
      exp_q.delete();
      foreach (os_q[k]) os_q[k][AW] = 1'b1;
      m_pc   = i_jump_pc & ~32'h3;
      m_halt = 1'b0;
    end else begin
      if (eiv && i_instr_ready) void'(exp_q.pop_front());
      if (i_ifu_vrb_rsp_valid && !t[AW]) begin
        exp_q.push_back({i_ifu_vrb_rsp_err, mem_word(t[AW-1:0]), t[AW-1:0]});
        if (i_ifu_vrb_rsp_err) m_halt = 1'b1;
      end
      if (ecv && i_ifu_vrb_cmd_ready) begin
        os_q.push_back({1'b0, m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    // bus side and logs follow the DUT's actual transfers
    if (i_ifu_vrb_rsp_valid) void'(bus_q.pop_front());
    if (o_ifu_vrb_cmd_valid && i_ifu_vrb_cmd_ready) begin
      bus_q.push_back(o_ifu_vrb_cmd_addr);
      acc_log.push_back(o_ifu_vrb_cmd_addr);
    end
    if (o_instr_valid && i_instr_ready) begin
      pc_log.push_back(o_pc);
      err_log.push_back(o_err);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_jump_valid = 1'b0;
    i_ifu_vrb_cmd_ready = 1'b0;
    i_ifu_vrb_rsp_valid = 1'b0;
    i_ifu_vrb_rsp_err = 1'b0;
    i_instr_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      #1;
      chk("rst_cmd_valid", o_ifu_vrb_cmd_valid, 1'b0);
      chk("rst_instr_valid", o_instr_valid, 1'b0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus_q.delete();
    exp_q.delete();
    os_q.delete();
    m_pc = '0;
    m_halt = 1'b0;
    acc_log.delete();
    pc_log.delete();
    err_log.delete();
  endtask

  // Leaves reads for 0x8 and 0xC in flight with an empty FIFO.
  task automatic setup_8c();
    do_reset();
    for (int n = 0; n < 20 && !(bus_q.size() == 2 && bus_q[0] == 32'h8); n++) begin
      drive(1'b0, '0, 1'b1, (bus_q.size() > 0 && bus_q[0] < 32'h8), 1'b0, 1'b1);
      advance();
    end
    chk("setup_8c", (bus_q.size() == 2 && bus_q[0] == 32'h8 && bus_q[1] == 32'hC), 1'b1);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && bus_q.size() > 0; n++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
      advance();
    end
    chk("drain", bus_q.size(), 0);
  endtask

  task automatic wait_first_pop();
    for (int n = 0; n < 30 && pc_log.size() == 0; n++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
      advance();
    end
    chk("first_pop_timeout", pc_log.size() > 0, 1'b1);
  endtask

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    @(negedge clk);

    // --- in-order stream, response one cycle after accept ---
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("a_first_addr", o_ifu_vrb_cmd_addr, 32'h0);
    advance();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("a_no_instr_c1", o_instr_valid, 1'b0);
    chk("a_second_addr", o_ifu_vrb_cmd_addr, 32'h4);
    advance();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("a_instr_valid_c2", o_instr_valid, 1'b1);
    chk("a_pc_c2", o_pc, 32'h0);
    chk("a_instr_c2", o_instr, 32'h5A5A_0F0F);
    advance();
    repeat (6) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
      advance();
    end
    chk("a_acc_count", acc_log.size() >= 3, 1'b1);
    chk("a_pop_count", pc_log.size() >= 3, 1'b1);
    if (acc_log.size() >= 3 && pc_log.size() >= 3) begin
      chk("a_acc_seq", {acc_log[0], acc_log[1], acc_log[2]}, {32'h0, 32'h4, 32'h8});
      chk("a_pc_seq", {pc_log[0], pc_log[1], pc_log[2]}, {32'h0, 32'h4, 32'h8});
    end

    // --- decode stalled: credit limit fills the FIFO exactly ---
    do_reset();
    repeat (8) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      advance();
    end
    chk("b_accepts", acc_log.size(), 4);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("b_full_no_cmd", o_ifu_vrb_cmd_valid, 1'b0);
    chk("b_head_pc0", o_pc, 32'h0);
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b_refill_valid", o_ifu_vrb_cmd_valid, 1'b1);
    chk("b_refill_addr", o_ifu_vrb_cmd_addr, 32'h10);
    advance();
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("b_head_seq", o_pc, 32'(k * 4));
      advance();
    end
    drain();

    // --- jump with two reads in flight ---
    setup_8c();
    acc_log.delete();
    pc_log.delete();
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("c_jump_hides_head", o_instr_valid, 1'b0);
    chk("c_jump_no_cmd", o_ifu_vrb_cmd_valid, 1'b0);
    advance();
    wait_first_pop();
    if (acc_log.size() > 0) chk("c_first_cmd", acc_log[0], 32'h100);
    if (pc_log.size() > 0) chk("c_first_pc", pc_log[0], 32'h100);
    drain();

    // --- jump in the same cycle as the response for 0x8 ---
    setup_8c();
    acc_log.delete();
    pc_log.delete();
    drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1);
    advance();
    wait_first_pop();
    if (acc_log.size() > 0) chk("d_first_cmd", acc_log[0], 32'h200);
    if (pc_log.size() > 0) chk("d_first_pc", pc_log[0], 32'h200);
    drain();

    // --- bus error halts fetching until a jump ---
    setup_8c();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    advance();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("e_err_valid", o_instr_valid, 1'b1);
    chk("e_err_pc", o_pc, 32'h8);
    chk("e_err_flag", o_err, 1'b1);
    chk("e_halt_no_cmd", o_ifu_vrb_cmd_valid, 1'b0);
    advance();
    repeat (4) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("e_halt_no_cmd", o_ifu_vrb_cmd_valid, 1'b0);
      advance();
    end
    drain();
    pc_log.delete();
    err_log.delete();
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("e_restart_valid", o_ifu_vrb_cmd_valid, 1'b1);
    chk("e_restart_addr", o_ifu_vrb_cmd_addr, 32'h40);
    advance();
    wait_first_pop();
    if (pc_log.size() > 0) chk("e_restart_pc", pc_log[0], 32'h40);
    if (err_log.size() > 0) chk("e_restart_err", err_log[0], 1'b0);
    drain();

    // --- jump target alignment and address wrap ---
    drive(1'b1, 32'h103, 1'b0, 1'b0, 1'b0, 1'b1);
    advance();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("f_align_addr", o_ifu_vrb_cmd_addr, 32'h100);
    advance();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b1);
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("f_top_addr", o_ifu_vrb_cmd_addr, 32'hFFFF_FFFC);
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("f_wrap_valid", o_ifu_vrb_cmd_valid, 1'b1);
    chk("f_wrap_addr", o_ifu_vrb_cmd_addr, 32'h0);
    advance();
    drain();

    // --- randomized traffic ---
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) < 7);
      advance();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
